// File: rtl/uart_pkg.sv
// Shared UART definitions for the "ok<CR>" console exchange.
// OKTX_APPEND_LF_EN: when defined, the reply carries a trailing LF.
package uart_pkg;

  localparam logic [7:0] ASCII_O  = 8'd111;
  localparam logic [7:0] ASCII_K  = 8'd107;
  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

`ifdef OKTX_APPEND_LF_EN
  localparam int MSG_LEN = 4;
`else
  localparam int MSG_LEN = 3;
`endif

  localparam int IDX_W = 2;

  // Index 3 is only reachable when the LF byte is enabled.
  function automatic logic [7:0] msg_byte(
    input logic [IDX_W-1:0] idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = ASCII_O;
      2'd1:    b = ASCII_K;
      2'd2:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serialiser, LSB first.
// Start accepted in IDLE or on FrameDone for back-to-back frames.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       Clk50M,
  input  logic       Rst,
  input  logic       Start,
  input  logic [7:0] Data,
  output logic       TxD,
  output logic       Busy,
  output logic       FrameDone
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tick;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    FrameDone = 1'b0;
    if (state_q != ST_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_START;
          cnt_d   = '0;
          data_d  = Data;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          FrameDone = 1'b1;
          if (Start) begin
            state_d = ST_START;
            data_d  = Data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    TxD = 1'b1;
    case (state_q)
      ST_START: TxD = 1'b0;
      ST_DATA:  TxD = data_q[bit_q];
      default:  TxD = 1'b1;
    endcase
  end

  assign Busy = (state_q != ST_IDLE);

endmodule

// File: rtl/ok_reply_tx.sv
// Sends the fixed "ok<CR>" reply (plus LF with OKTX_APPEND_LF_EN)
// as back-to-back 8N1 frames on a one-cycle SendPulse.
module ok_reply_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk50M,
  input  logic Rst,
  input  logic SendPulse,
  output logic TxD,
  output logic Busy,
  output logic DonePulse
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             tx_start, tx_busy;
  logic             frame_done;
  logic [7:0]       tx_data;
  logic             last_byte, accept;

  assign last_byte = (idx_q == IDX_W'(MSG_LEN - 1));
  assign accept    = SendPulse & ~busy_q & ~tx_busy;

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  // Next frame is queued on FrameDone so no idle gap appears.
  always_comb begin
    idx_d     = idx_q;
    busy_d    = busy_q;
    tx_start  = 1'b0;
    tx_data   = msg_byte(idx_q + IDX_W'(1));
    DonePulse = 1'b0;
    if (accept) begin
      idx_d    = '0;
      busy_d   = 1'b1;
      tx_start = 1'b1;
      tx_data  = msg_byte('0);
    end else if (busy_q && frame_done) begin
      if (last_byte) begin
        idx_d     = '0;
        busy_d    = 1'b0;
        DonePulse = 1'b1;
      end else begin
        idx_d    = idx_q + IDX_W'(1);
        tx_start = 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clk50M   (Clk50M),
    .Rst      (Rst),
    .Start    (tx_start),
    .Data     (tx_data),
    .TxD      (TxD),
    .Busy     (tx_busy),
    .FrameDone(frame_done)
  );

  assign Busy = busy_q;

endmodule
